// File: rtl/ecat_sched_pkg.sv
// ---------------------------------------------------------------------------
// ecat_sched_pkg
// Shared definitions for the EtherCAT cycle scheduler:
//   - Avalon-MM register word addresses
//   - CONTROL register bit positions
//   - transfer FSM state encoding
// ---------------------------------------------------------------------------
package ecat_sched_pkg;

    // Register word addresses (3-bit Avalon address)
    localparam logic [2:0] ADDR_STATUS      = 3'd0;
    localparam logic [2:0] ADDR_CONTROL     = 3'd1;
    localparam logic [2:0] ADDR_DIVIDER     = 3'd2;
    localparam logic [2:0] ADDR_SYNC_WIDTH  = 3'd3;
    localparam logic [2:0] ADDR_CYCLE_CNT   = 3'd4;
    localparam logic [2:0] ADDR_OVERRUN_CNT = 3'd5;

    // CONTROL register bit indices
    localparam int CTRL_ENABLE         = 0;
    localparam int CTRL_IRQ_EN_OVERRUN = 1;
    localparam int CTRL_IRQ_EN_TIMEOUT = 2;
    localparam int CTRL_SOFT_TRIG      = 3;

    // Transfer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/ecat_sync_stretch.sv
// ---------------------------------------------------------------------------
// ecat_sync_stretch
// Pulse stretcher for the SYNC output. On start the width is loaded into a
// down-counter; the output is high while the counter is non-zero, giving a
// pulse of exactly `width` clocks beginning on the clock after start.
// A width of 0 produces no pulse.
// Ports:
//   clk       in   system clock
//   reset_n   in   asynchronous active-low reset
//   start     in   1-cycle load strobe
//   width     in   16-bit pulse length in clocks, sampled on start
//   pulse_out out  stretched pulse level
// ---------------------------------------------------------------------------
module ecat_sync_stretch (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] width,
    output logic        pulse_out
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = width;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign pulse_out = (cnt_q != 16'd0);

endmodule

// File: rtl/ecat_cycle_scheduler.sv
// ---------------------------------------------------------------------------
// ecat_cycle_scheduler
// Divides interval-timer ticks into EtherCAT process-data cycles, launches one
// SPI transfer per cycle over a req/ack/done handshake, drives a stretched SYNC
// pulse, and tracks completed cycles, overruns and transfer timeouts behind a
// 16-bit Avalon-MM slave with a level interrupt.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   address/chipselect/write_n/
//   writedata/readdata                Avalon-MM slave, read latency 1
//   irq                               level interrupt from sticky flags
//   timer_pulse                       1-cycle tick from interval timer
//   xfer_req/xfer_ack/xfer_done       transfer handshake to SPI master
//   sync_out                          SYNC pulse, SYNC_WIDTH clocks per launch
// ---------------------------------------------------------------------------
module ecat_cycle_scheduler
    import ecat_sched_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [15:0] SYNC_W_RESET   = 16'd100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    input  logic        timer_pulse,
    output logic        xfer_req,
    input  logic        xfer_ack,
    input  logic        xfer_done,
    output logic        sync_out
);

    localparam int            TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    sched_state_e  state_q, state_d;
    logic [TW-1:0] timer_cnt_q, timer_cnt_d;
    logic [2:0]    control_q, control_d;
    logic [7:0]    divider_q, divider_d;
    logic [15:0]   sync_width_q, sync_width_d;
    logic [15:0]   cycle_cnt_q, cycle_cnt_d;
    logic [15:0]   overrun_cnt_q, overrun_cnt_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    div_cnt_q, div_cnt_d;
    logic [15:0]   readdata_q, readdata_d;

    logic wr_en, rd_en;
    logic enable, soft_trig, timer_trig, trigger, busy;
    logic launch, overrun_evt, done_evt, timeout_evt;

    // ---------------- trigger generation ----------------
    always_comb begin
        wr_en       = chipselect & ~write_n;
        rd_en       = chipselect & write_n;
        enable      = control_q[CTRL_ENABLE];
        soft_trig   = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_SOFT_TRIG];
        timer_trig  = enable && timer_pulse && (div_cnt_q == divider_q);
        trigger     = timer_trig | soft_trig;
        busy        = (state_q != IDLE);
        // A trigger is only launched from IDLE; otherwise it is an overrun.
        launch      = trigger & ~busy;
        overrun_evt = trigger & busy;

        div_cnt_d = div_cnt_q;
        if (!enable || (wr_en && (address == ADDR_DIVIDER))) begin
            div_cnt_d = 8'd0;
        end else if (timer_pulse) begin
            div_cnt_d = (div_cnt_q == divider_q) ? 8'd0 : div_cnt_q + 8'd1;
        end
    end

    // ---------------- transfer FSM ----------------
    always_comb begin
        state_d     = state_q;
        timer_cnt_d = timer_cnt_q + TW'(1);
        done_evt    = 1'b0;
        timeout_evt = 1'b0;
        case (state_q)
            IDLE: begin
                timer_cnt_d = '0;
                if (launch) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // done while still requesting implies the ack as well
                if (xfer_done) begin
                    state_d  = IDLE;
                    done_evt = 1'b1;
                end else if (timer_cnt_q == TIMER_LAST) begin
                    state_d     = IDLE;
                    timeout_evt = 1'b1;
                end else if (xfer_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (xfer_done) begin
                    state_d  = IDLE;
                    done_evt = 1'b1;
                end else if (timer_cnt_q == TIMER_LAST) begin
                    state_d     = IDLE;
                    timeout_evt = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- registers and counters ----------------
    always_comb begin
        control_d     = control_q;
        divider_d     = divider_q;
        sync_width_d  = sync_width_q;
        cycle_cnt_d   = cycle_cnt_q;
        overrun_cnt_d = overrun_cnt_q;
        timeout_d     = timeout_q;
        overrun_d     = overrun_q;
        readdata_d    = 16'd0;

        if (wr_en) begin
            case (address)
                ADDR_STATUS: begin
                    timeout_d = 1'b0;
                    overrun_d = 1'b0;
                end
                ADDR_CONTROL:     control_d     = writedata[2:0];
                ADDR_DIVIDER:     divider_d     = writedata[7:0];
                ADDR_SYNC_WIDTH:  sync_width_d  = writedata;
                ADDR_OVERRUN_CNT: overrun_cnt_d = 16'd0;
                default: ;
            endcase
        end

        // Events are applied after the bus clears so a coincident set wins.
        if (timeout_evt) begin
            timeout_d = 1'b1;
        end
        if (overrun_evt) begin
            overrun_d     = 1'b1;
            overrun_cnt_d = (overrun_cnt_q == 16'hFFFF) ? overrun_cnt_q : overrun_cnt_q + 16'd1;
        end
        if (done_evt) begin
            cycle_cnt_d = cycle_cnt_q + 16'd1;
        end

        if (rd_en) begin
            case (address)
                ADDR_STATUS:      readdata_d = {13'd0, timeout_q, overrun_q, busy};
                ADDR_CONTROL:     readdata_d = {13'd0, control_q};
                ADDR_DIVIDER:     readdata_d = {8'd0, divider_q};
                ADDR_SYNC_WIDTH:  readdata_d = sync_width_q;
                ADDR_CYCLE_CNT:   readdata_d = cycle_cnt_q;
                ADDR_OVERRUN_CNT: readdata_d = overrun_cnt_q;
                default:          readdata_d = 16'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            timer_cnt_q   <= '0;
            control_q     <= 3'd0;
            divider_q     <= 8'd0;
            sync_width_q  <= SYNC_W_RESET;
            cycle_cnt_q   <= 16'd0;
            overrun_cnt_q <= 16'd0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            div_cnt_q     <= 8'd0;
            readdata_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            timer_cnt_q   <= timer_cnt_d;
            control_q     <= control_d;
            divider_q     <= divider_d;
            sync_width_q  <= sync_width_d;
            cycle_cnt_q   <= cycle_cnt_d;
            overrun_cnt_q <= overrun_cnt_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            div_cnt_q     <= div_cnt_d;
            readdata_q    <= readdata_d;
        end
    end

    // Width is sampled at launch, so a SYNC_WIDTH write mid-pulse only
    // affects the next pulse.
    ecat_sync_stretch u_sync_stretch (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (launch),
        .width     (sync_width_q),
        .pulse_out (sync_out)
    );

    assign xfer_req = (state_q == REQ);
    assign readdata = readdata_q;
    assign irq      = (overrun_q & control_q[CTRL_IRQ_EN_OVERRUN])
                    | (timeout_q & control_q[CTRL_IRQ_EN_TIMEOUT]);

endmodule
